// File: rtl/console_pkg.sv
// Shared console definitions: serializer states, line-level bit constants
// and the character width used by both the keyboard and console paths.
package console_pkg;

  // Serializer states; PARITY is only visited when CONSOLE_TX_PARITY_EN is defined
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // ASCII character width, shared with the keyboard receive path
  localparam int CHAR_W = 7;

  // Even parity over a full 8-bit data field (1 when the count of ones is odd)
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/console_uart_tx.sv
// UART frame serializer: baud counter, shift register and state machine.
// Pulls one character per frame through a valid/ready pop handshake.
// Optional feature: CONSOLE_TX_PARITY_EN inserts an even-parity bit before STOP.
module console_uart_tx
  import console_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pop_valid_i,
  output logic              pop_ready_o,
  input  logic [CHAR_W-1:0] pop_data_i,
  output logic              tx_o,
  output logic              busy_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  tx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             busy_q;
`ifdef CONSOLE_TX_PARITY_EN
  logic             par_q;
`endif

  logic bit_end;
  assign bit_end = (cnt_q == CNT_LAST);

  // The serializer only accepts a new character between frames
  assign pop_ready_o = (state_q == ST_IDLE);
  assign tx_o        = tx_q;
  assign busy_o      = busy_q;

  // Frame sequencer; the line register follows the state one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= STOP_BIT;
      busy_q  <= 1'b0;
`ifdef CONSOLE_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q  <= STOP_BIT;
          cnt_q <= '0;
          if (pop_valid_i) begin
            shift_q <= {1'b0, pop_data_i};
`ifdef CONSOLE_TX_PARITY_EN
            par_q   <= even_parity({1'b0, pop_data_i});
`endif
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
        end

        ST_START: begin
          tx_q <= START_BIT;
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= ST_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          tx_q <= shift_q[0];
          if (bit_end) begin
            cnt_q   <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) begin
`ifdef CONSOLE_TX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

`ifdef CONSOLE_TX_PARITY_EN
        ST_PARITY: begin
          tx_q <= par_q;
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          tx_q <= STOP_BIT;
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          tx_q    <= STOP_BIT;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/console_tx_interface.sv
// Console transmit path: CPU writes 7-bit characters into an inline FIFO,
// which feeds the console_uart_tx serializer driving the UART TX pin.
// Optional feature: CONSOLE_TX_PARITY_EN (even parity bit, 8E1 framing).
module console_tx_interface
  import console_pkg::*;
#(
  parameter int CLK_HZ     = 20_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              DP_write_en,
  input  logic [CHAR_W-1:0] DP_data,
  input  logic              DP_clear,
  output logic              DP_status,
  output logic              buf_empty,
  output logic              buf_overflow,
  output logic              tx_busy,
  output logic              tx_out
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [CHAR_W-1:0] mem_q [FIFO_DEPTH];

  logic status_q, empty_q, overflow_q;
  logic fifo_full, fifo_empty, full_next, empty_next;
  logic wr_accept, pop_valid, pop_ready, pop_fire;

  // Occupancy from the pre-edge pointers decides acceptance this cycle
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);

  // A flush discards any simultaneous write and withholds the pop
  assign wr_accept = DP_write_en && !DP_clear && !fifo_full;
  assign pop_valid = !fifo_empty && !DP_clear;
  assign pop_fire  = pop_valid && pop_ready;

  // Next pointer values; flush collapses the read pointer onto the write pointer
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (DP_clear) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  assign full_next  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  assign empty_next = (wr_ptr_d == rd_ptr_d);

  // Pointer and status registers; status reflects occupancy after the edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      status_q   <= 1'b1;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      status_q <= !full_next;
      empty_q  <= empty_next;
      if (DP_clear) begin
        overflow_q <= 1'b0;
      end else if (DP_write_en && fifo_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Character storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q[AW-1:0]] <= DP_data;
    end
  end

  console_uart_tx #(
    .DIV (DIV)
  ) u_uart_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .pop_valid_i (pop_valid),
    .pop_ready_o (pop_ready),
    .pop_data_i  (mem_q[rd_ptr_q[AW-1:0]]),
    .tx_o        (tx_out),
    .busy_o      (tx_busy)
  );

  assign DP_status    = status_q;
  assign buf_empty    = empty_q;
  assign buf_overflow = overflow_q;

endmodule

// File: tb/tb_console_tx_interface.sv
// Bench for console_tx_interface: a frame-timeline model checked every cycle,
// a line monitor that decodes received characters, and literal expectations.
module tb_console_tx_interface;

  localparam int DIV   = 10;
  localparam int DEPTH = 8;
`ifdef CONSOLE_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [NB-1:0] EXP_A    = 11'b10010000010;
  localparam int            BUSY_LIT = 110;
`else
  localparam int NB = 10;
  localparam logic [NB-1:0] EXP_A    = 10'b1010000010;
  localparam int            BUSY_LIT = 100;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       DP_write_en = 1'b0;
  logic [6:0] DP_data = '0;
  logic       DP_clear = 1'b0;
  logic       DP_status, buf_empty, buf_overflow, tx_busy, tx_out;

  always #5 clk = ~clk;

  console_tx_interface #(
    .CLK_HZ     (20_000_000),
    .BAUD       (2_000_000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .DP_write_en  (DP_write_en),
    .DP_data      (DP_data),
    .DP_clear     (DP_clear),
    .DP_status    (DP_status),
    .buf_empty    (buf_empty),
    .buf_overflow (buf_overflow),
    .tx_busy      (tx_busy),
    .tx_out       (tx_out)
  );

  int tests = 0;
  int fails = 0;
  int nprint = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Line image of one character, index 0 is the first bit on the wire
  function automatic logic [NB-1:0] frame_of(input logic [6:0] c);
`ifdef CONSOLE_TX_PARITY_EN
    return {1'b1, ^c, 1'b0, c, 1'b0};
`else
    return {1'b1, 1'b0, c, 1'b0};
`endif
  endfunction

  // Model: queue of characters plus "edges since the current frame was popped"
  logic [6:0]    mq[$];
  int            mk = FRAME;
  logic [NB-1:0] mbits = '1;
  logic          movf = 1'b0;
  int            m_n;
  logic          m_busy_pre;
  logic [6:0]    m_c;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      mk   = FRAME;
      movf = 1'b0;
    end else begin
      m_n        = mq.size();
      m_busy_pre = (mk < FRAME);
      if (mk < FRAME) mk++;
      if (!m_busy_pre && m_n > 0 && !DP_clear) begin
        m_c   = mq.pop_front();
        mbits = frame_of(m_c);
        mk    = 0;
      end
      if (DP_clear) begin
        mq.delete();
        movf = 1'b0;
      end else if (DP_write_en) begin
        if (m_n == DEPTH) movf = 1'b1;
        else mq.push_back(DP_data);
      end
    end
  end

  // Per-cycle comparison of all outputs against the model
  logic [4:0] exp_v, got_v;
  logic       exp_tx;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      exp_tx = (mk >= 1 && mk < FRAME) ? mbits[(mk - 1) / DIV] : 1'b1;
      exp_v  = {exp_tx, (mk < FRAME), (mq.size() < DEPTH), (mq.size() == 0), movf};
      got_v  = {tx_out, tx_busy, DP_status, buf_empty, buf_overflow};
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL cycle_model {tx,busy,status,empty,ovf} got=%b expected=%b at %0t",
                   got_v, exp_v, $time);
        end
      end
    end
  end

  // Line monitor: decodes each frame's 7-bit character into rxq
  logic [6:0] rxq[$];
  logic [7:0] rx_d;
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && tx_out === 1'b0) begin
      repeat (4) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        repeat (DIV) @(negedge clk);
        rx_d[b] = tx_out;
      end
      repeat (DIV * (NB - 9)) @(negedge clk);
      rxq.push_back(rx_d[6:0]);
    end
  end

  // All stimulus tasks start and end on a falling edge
  task automatic wr(input logic [6:0] c);
    DP_write_en = 1'b1;
    DP_data     = c;
    @(negedge clk);
    DP_write_en = 1'b0;
  endtask

  task automatic single(input logic [6:0] c, output logic [NB-1:0] bits, output int busy_n);
    busy_n = 0;
    bits   = '0;
    wr(c);
    for (int i = 1; i <= FRAME + 30; i++) begin
      @(negedge clk);
      if (tx_busy) busy_n++;
      if (i == 1) chk("latency_idle_after_pop", tx_out, 1);
      if (i == 2) chk("latency_start_bit", tx_out, 0);
      if (i >= 7 && (i - 7) % DIV == 0 && (i - 7) / DIV < NB) bits[(i - 7) / DIV] = tx_out;
    end
  endtask

  logic [NB-1:0] fb;
  int            bn;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_tx_out", tx_out, 1);
    chk("reset_status", DP_status, 1);
    chk("reset_empty", buf_empty, 1);
    chk("reset_overflow", buf_overflow, 0);
    chk("reset_busy", tx_busy, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single character 'A'
    single(7'h41, fb, bn);
    chk("A_frame_bits", fb, EXP_A);
    chk("A_busy_cycles", bn, BUSY_LIT);
    chk("A_empty_after", buf_empty, 1);

    // Fill and overflow
    rxq.delete();
    for (int i = 0; i < 9; i++) wr(7'h61 + 7'(i));
    chk("fill_status_full", DP_status, 0);
    chk("fill_not_empty", buf_empty, 0);
    wr(7'h7A);
    chk("fill_overflow_set", buf_overflow, 1);
    repeat (9 * (FRAME + 1) + 30) @(negedge clk);
    chk("fill_rx_count", rxq.size(), 9);
    for (int i = 0; i < 9; i++) chk("fill_rx_order", rxq[i], 7'h61 + 7'(i));
    chk("fill_status_drained", DP_status, 1);

    // Clear mid-frame, with a write in the same cycle as the clear
    rxq.delete();
    wr(7'h31);
    wr(7'h32);
    wr(7'h33);
    repeat (35) @(negedge clk);
    DP_clear    = 1'b1;
    DP_write_en = 1'b1;
    DP_data     = 7'h39;
    @(negedge clk);
    DP_clear    = 1'b0;
    DP_write_en = 1'b0;
    chk("clear_empty", buf_empty, 1);
    chk("clear_overflow", buf_overflow, 0);
    chk("clear_busy_inflight", tx_busy, 1);
    repeat (3 * FRAME) @(negedge clk);
    chk("clear_rx_count", rxq.size(), 1);
    chk("clear_rx_first", rxq[0], 7'h31);

    // Pointer wrap: 20 characters paced so the FIFO never fills
    rxq.delete();
    for (int i = 0; i < 20; i++) begin
      wr(7'h40 + 7'(i));
      repeat (8 * DIV - 1) @(negedge clk);
    end
    repeat (8 * FRAME) @(negedge clk);
    chk("wrap_rx_count", rxq.size(), 20);
    for (int i = 0; i < 20; i++) chk("wrap_rx_order", rxq[i], 7'h40 + 7'(i));
    chk("wrap_no_overflow", buf_overflow, 0);

    // Asynchronous reset in the middle of an all-zero data field
    wr(7'h00);
    repeat (40) @(negedge clk);
    chk("pre_reset_line_low", tx_out, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_tx_out", tx_out, 1);
    chk("async_reset_busy", tx_busy, 0);
    chk("async_reset_empty", buf_empty, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (130) @(negedge clk);
    rxq.delete();
    wr(7'h30);
    repeat (FRAME + 20) @(negedge clk);
    chk("post_reset_rx_count", rxq.size(), 1);
    chk("post_reset_rx_char", rxq[0], 7'h30);

`ifdef CONSOLE_TX_PARITY_EN
    single(7'h41, fb, bn);
    chk("parity_41_bit", fb[9], 0);
    chk("parity_41_busy", bn, 110);
    single(7'h43, fb, bn);
    chk("parity_43_bit", fb[9], 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
